// File: rtl/if_stage_mo.sv
// Instruction-fetch stage with several requests in flight on the SRAM-like bus, a small
// instruction buffer toward decode, delay-slot-correct branch redirect, exception/eret
// flush with discard of in-flight responses, and AdEL detection on misaligned PCs.
module if_stage_mo #(
  parameter logic [31:0] RESET_PC        = 32'hbfc00000,
  parameter logic [31:0] EX_VECTOR       = 32'hbfc00380,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned IBUF_DEPTH      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ds_allowin,
  input  logic [34:0] br_bus,
  input  logic        ws_ex,
  input  logic        ws_eret,
  input  logic [31:0] cp0_epc,
  output logic        fs_to_ds_valid,
  output logic [70:0] fs_to_ds_bus,
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [3:0]  inst_sram_wstrb,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata
);

  localparam int unsigned OutW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PtrW = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(IBUF_DEPTH + 1);

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (32'(p) == IBUF_DEPTH - 1) ? '0 : p + PtrW'(1);
  endfunction

  // Fetch PC and redirect state
  logic [31:0] pf_pc_q, pf_pc_d;
  logic        redir_q, redir_d;
  logic [31:0] redir_pc_q, redir_pc_d;
  logic        mis_stop_q, mis_stop_d;
  logic        bd_q, bd_d;

  // Pending FIFO: index 0 is the oldest accepted request
  logic [OutW-1:0]            out_q, out_d;
  logic [31:0]                pend_pc_q [MAX_OUTSTANDING];
  logic [31:0]                pend_pc_d [MAX_OUTSTANDING];
  logic [MAX_OUTSTANDING-1:0] pend_kill_q, pend_kill_d, kill_nx;

  // Instruction buffer
  logic [31:0]     ib_pc_q   [IBUF_DEPTH];
  logic [31:0]     ib_inst_q [IBUF_DEPTH];
  logic [4:0]      ib_code_q [IBUF_DEPTH];
  logic            ib_ex_q   [IBUF_DEPTH];
  logic [PtrW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic        br_op, br_stall, br_taken, br_fire;
  logic [31:0] br_target;
  logic        flush;
  logic [31:0] flush_pc;
  logic        ib_empty, ib_pop, ib_push, resp, resp_keep, req_fire, mis_push;
  logic        slot_found, push_kill;
  logic [OutW-1:0] push_idx;
  logic [31:0] push_pc, push_inst;
  logic [4:0]  push_code;
  logic        push_ex;

  assign br_op     = br_bus[34];
  assign br_stall  = br_bus[33];
  assign br_taken  = br_bus[32];
  assign br_target = br_bus[31:0];

  assign flush    = ws_ex | ws_eret;
  assign flush_pc = ws_ex ? EX_VECTOR : cp0_epc;
  // A flush squashes the branch in decode as well
  assign br_fire  = br_taken & ~br_stall & ~flush;

  assign ib_empty       = (cnt_q == '0);
  assign fs_to_ds_valid = ~ib_empty & ~flush;
  assign ib_pop         = fs_to_ds_valid & ds_allowin;
  assign fs_to_ds_bus   = {bd_q, ib_ex_q[rd_q], ib_code_q[rd_q], ib_inst_q[rd_q], ib_pc_q[rd_q]};

  // Buffer room counts in-flight requests so every response has a slot to land in
  assign inst_sram_req = ~reset & ~br_stall & ~flush & (pf_pc_q[1:0] == 2'b00) & ~mis_stop_q
                       & (32'(out_q) < MAX_OUTSTANDING)
                       & ((32'(cnt_q) + 32'(out_q)) < IBUF_DEPTH);
  assign inst_sram_addr  = pf_pc_q;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'd2;
  assign inst_sram_wstrb = 4'd0;
  assign inst_sram_wdata = 32'd0;

  assign req_fire = inst_sram_req & inst_sram_addr_ok;
  assign resp     = inst_sram_data_ok;

  // Locate the delay slot (oldest live instruction) and kill everything younger
  always_comb begin
    logic seen;
    kill_nx = pend_kill_q;
    seen    = ~ib_empty;
    if (flush) begin
      kill_nx = '1;
    end else if (br_fire) begin
      for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
        if ((i < int'(out_q)) && !pend_kill_q[i]) begin
          if (seen) kill_nx[i] = 1'b1;
          else      seen       = 1'b1;
        end
      end
    end
    slot_found = seen;
    // A request accepted alongside a branch is younger than an already-found delay slot
    push_kill  = br_fire & seen;
  end

  assign resp_keep = resp & ~kill_nx[0];
  assign mis_push  = ~flush & ~br_fire & (pf_pc_q[1:0] != 2'b00) & ~mis_stop_q
                   & (out_q == '0) & (32'(cnt_q) < IBUF_DEPTH);
  assign ib_push   = resp_keep | mis_push;

  // Select what enters the buffer: a returned word or an AdEL marker
  always_comb begin
    push_pc   = pend_pc_q[0];
    push_inst = inst_sram_rdata;
    push_code = 5'h00;
    push_ex   = 1'b0;
    if (mis_push) begin
      push_pc   = pf_pc_q;
      push_inst = 32'd0;
      push_code = 5'h04;
      push_ex   = 1'b1;
    end
  end

  // Pending FIFO and outstanding count next state
  always_comb begin
    pend_pc_d   = pend_pc_q;
    pend_kill_d = kill_nx;
    out_d       = out_q + OutW'(req_fire) - OutW'(resp);
    push_idx    = out_q - OutW'(resp);
    if (resp) begin
      for (int i = 0; i < int'(MAX_OUTSTANDING) - 1; i++) begin
        pend_pc_d[i]   = pend_pc_q[i+1];
        pend_kill_d[i] = kill_nx[i+1];
      end
      pend_pc_d[MAX_OUTSTANDING-1]   = '0;
      pend_kill_d[MAX_OUTSTANDING-1] = 1'b0;
    end
    if (req_fire) begin
      for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
        if (OutW'(i) == push_idx) begin
          pend_pc_d[i]   = pf_pc_q;
          pend_kill_d[i] = push_kill;
        end
      end
    end
  end

  // Fetch PC, redirect, misalign stop and delay-slot flag next state
  always_comb begin
    pf_pc_d    = pf_pc_q;
    redir_d    = redir_q;
    redir_pc_d = redir_pc_q;
    mis_stop_d = mis_stop_q;
    bd_d       = bd_q;
    if (flush) begin
      pf_pc_d    = flush_pc;
      redir_d    = 1'b0;
      mis_stop_d = 1'b0;
    end else begin
      if (br_fire) begin
        if (slot_found || req_fire) begin
          // Delay slot already fetched (or being accepted now): jump straight away
          pf_pc_d = br_target;
          redir_d = 1'b0;
        end else begin
          redir_d    = 1'b1;
          redir_pc_d = br_target;
        end
      end else if (req_fire) begin
        pf_pc_d = redir_q ? redir_pc_q : pf_pc_q + 32'd4;
        redir_d = 1'b0;
      end
      if (mis_push) mis_stop_d = 1'b1;
    end
    if (ib_pop) bd_d = 1'b0;
    if (br_op)  bd_d = 1'b1;
    if (flush)  bd_d = 1'b0;
  end

  // Instruction buffer pointer/count next state
  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else if (br_fire && !ib_empty) begin
      // Head is the delay slot: keep it, drop everything behind it
      wr_d = ptr_inc(rd_q);
      if (ib_pop) begin
        rd_d  = ptr_inc(rd_q);
        cnt_d = '0;
      end else begin
        cnt_d = CntW'(1);
      end
    end else begin
      if (ib_push) wr_d = ptr_inc(wr_q);
      if (ib_pop)  rd_d = ptr_inc(rd_q);
      cnt_d = cnt_q + CntW'(ib_push) - CntW'(ib_pop);
    end
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pf_pc_q     <= RESET_PC;
      redir_q     <= 1'b0;
      redir_pc_q  <= '0;
      mis_stop_q  <= 1'b0;
      bd_q        <= 1'b0;
      out_q       <= '0;
      pend_kill_q <= '0;
      rd_q        <= '0;
      wr_q        <= '0;
      cnt_q       <= '0;
      for (int i = 0; i < int'(MAX_OUTSTANDING); i++) pend_pc_q[i] <= '0;
      for (int i = 0; i < int'(IBUF_DEPTH); i++) begin
        ib_pc_q[i]   <= '0;
        ib_inst_q[i] <= '0;
        ib_code_q[i] <= '0;
        ib_ex_q[i]   <= 1'b0;
      end
    end else begin
      pf_pc_q     <= pf_pc_d;
      redir_q     <= redir_d;
      redir_pc_q  <= redir_pc_d;
      mis_stop_q  <= mis_stop_d;
      bd_q        <= bd_d;
      out_q       <= out_d;
      pend_kill_q <= pend_kill_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      cnt_q       <= cnt_d;
      pend_pc_q   <= pend_pc_d;
      if (ib_push) begin
        ib_pc_q[wr_q]   <= push_pc;
        ib_inst_q[wr_q] <= push_inst;
        ib_code_q[wr_q] <= push_code;
        ib_ex_q[wr_q]   <= push_ex;
      end
    end
  end

endmodule

// File: tb/tb_if_stage_mo.sv
// Directed bench for if_stage_mo: an in-order SRAM responder with per-request latency,
// logs of accepted requests and decode deliveries, and per-scenario checks.
module tb_if_stage_mo;

  logic        clk = 1'b0;
  logic        reset;
  logic        ds_allowin;
  logic [34:0] br_bus;
  logic        ws_ex, ws_eret;
  logic [31:0] cp0_epc;
  logic        fs_to_ds_valid;
  logic [70:0] fs_to_ds_bus;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;

  always #5 clk = ~clk;

  if_stage_mo dut (
    .clk              (clk),
    .reset            (reset),
    .ds_allowin       (ds_allowin),
    .br_bus           (br_bus),
    .ws_ex            (ws_ex),
    .ws_eret          (ws_eret),
    .cp0_epc          (cp0_epc),
    .fs_to_ds_valid   (fs_to_ds_valid),
    .fs_to_ds_bus     (fs_to_ds_bus),
    .inst_sram_req    (inst_sram_req),
    .inst_sram_wr     (inst_sram_wr),
    .inst_sram_size   (inst_sram_size),
    .inst_sram_wstrb  (inst_sram_wstrb),
    .inst_sram_addr   (inst_sram_addr),
    .inst_sram_wdata  (inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok),
    .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata  (inst_sram_rdata)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc;
  int lat;

  logic [31:0] mq_addr [$];
  int          mq_due  [$];
  logic [31:0] hs_addr [$];
  int          hs_cyc  [$];
  logic [70:0] dl_bus  [$];
  int          dl_cyc  [$];

  function automatic logic [31:0] hs_a(input int i);
    if (i < hs_addr.size()) return hs_addr[i];
    return 32'hxxxxxxxx;
  endfunction

  function automatic int hs_c(input int i);
    if (i < hs_cyc.size()) return hs_cyc[i];
    return -1;
  endfunction

  function automatic logic [70:0] dl_b(input int i);
    if (i < dl_bus.size()) return dl_bus[i];
    return {71{1'bx}};
  endfunction

  function automatic int dl_c(input int i);
    if (i < dl_cyc.size()) return dl_cyc[i];
    return -1;
  endfunction

  // One clock: drive the responder, sample at negedge+1, return at posedge+1
  task automatic tick();
    @(negedge clk);
    if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      inst_sram_data_ok = 1'b1;
      inst_sram_rdata   = ~mq_addr[0];
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end else begin
      inst_sram_data_ok = 1'b0;
      inst_sram_rdata   = 32'd0;
    end
    #1;
    if (inst_sram_req && inst_sram_addr_ok) begin
      hs_addr.push_back(inst_sram_addr);
      hs_cyc.push_back(cyc);
      mq_addr.push_back(inst_sram_addr);
      mq_due.push_back(cyc + lat);
    end
    if (fs_to_ds_valid && ds_allowin) begin
      dl_bus.push_back(fs_to_ds_bus);
      dl_cyc.push_back(cyc);
    end
    n_cmp++;
    if (mq_addr.size() > 2) begin
      n_bad++;
      $display("FAIL outstanding_bound cyc %0d: in flight %0d, limit 2", cyc, mq_addr.size());
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset             = 1'b1;
    ds_allowin        = 1'b1;
    br_bus            = '0;
    ws_ex             = 1'b0;
    ws_eret           = 1'b0;
    cp0_epc           = 32'd0;
    inst_sram_addr_ok = 1'b1;
    inst_sram_data_ok = 1'b0;
    inst_sram_rdata   = 32'd0;
    lat               = 1;
    mq_addr.delete();
    mq_due.delete();
    hs_addr.delete();
    hs_cyc.delete();
    dl_bus.delete();
    dl_cyc.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    cyc   = 0;
  endtask

  task automatic test_reset();
    do_reset();
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({inst_sram_req, fs_to_ds_valid, inst_sram_wr} !== 3'b000) begin
      n_bad++;
      $display("FAIL rst_ctrl: got req/valid/wr %b, want 000",
               {inst_sram_req, fs_to_ds_valid, inst_sram_wr});
    end
    n_cmp++;
    if (inst_sram_addr !== 32'hbfc00000 || inst_sram_size !== 2'd2) begin
      n_bad++;
      $display("FAIL rst_addr_size: got %h/%0d, want bfc00000/2", inst_sram_addr, inst_sram_size);
    end
    n_cmp++;
    if (inst_sram_wstrb !== 4'd0 || inst_sram_wdata !== 32'd0 || fs_to_ds_bus !== 71'd0) begin
      n_bad++;
      $display("FAIL rst_zero: got wstrb %h wdata %h bus %h, want all 0",
               inst_sram_wstrb, inst_sram_wdata, fs_to_ds_bus);
    end
    // Async reset in mid-run with a populated buffer
    do_reset();
    ds_allowin = 1'b0;
    repeat (4) tick();
    n_cmp++;
    if (fs_to_ds_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_pre_valid: got %b, want 1", fs_to_ds_valid);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (fs_to_ds_valid !== 1'b0 || inst_sram_addr !== 32'hbfc00000 || fs_to_ds_bus !== 71'd0) begin
      n_bad++;
      $display("FAIL rst_async: got valid %b addr %h bus %h, want 0 bfc00000 0",
               fs_to_ds_valid, inst_sram_addr, fs_to_ds_bus);
    end
  endtask

  task automatic test_sequential();
    do_reset();
    repeat (10) tick();
    for (int i = 0; i < 4; i++) begin
      logic [31:0] exp;
      logic [70:0] b;
      exp = 32'hbfc00000 + 32'(i * 4);
      n_cmp++;
      if (hs_a(i) !== exp) begin
        n_bad++;
        $display("FAIL seq_req_addr[%0d]: got %h, want %h", i, hs_a(i), exp);
      end
      b = dl_b(i);
      n_cmp++;
      if (b !== {7'd0, ~exp, exp}) begin
        n_bad++;
        $display("FAIL seq_deliver[%0d]: got %h, want %h", i, b, {7'd0, ~exp, exp});
      end
    end
    n_cmp++;
    if (dl_c(0) - hs_c(0) !== 2 || hs_c(0) !== 0) begin
      n_bad++;
      $display("FAIL seq_latency: got hs %0d dl %0d, want hs 0 dl 2", hs_c(0), dl_c(0));
    end
  endtask

  task automatic test_slow_response();
    int exp_c [0:2];
    do_reset();
    lat = 5;
    repeat (16) tick();
    exp_c = '{0, 1, 6};
    for (int i = 0; i < 3; i++) begin
      logic [31:0] exp;
      exp = 32'hbfc00000 + 32'(i * 4);
      n_cmp++;
      if (hs_a(i) !== exp || hs_c(i) !== exp_c[i]) begin
        n_bad++;
        $display("FAIL slow_req[%0d]: got %h@%0d, want %h@%0d", i, hs_a(i), hs_c(i), exp, exp_c[i]);
      end
      n_cmp++;
      if (dl_b(i) !== {7'd0, ~exp, exp}) begin
        n_bad++;
        $display("FAIL slow_deliver[%0d]: got %h, want pc %h", i, dl_b(i), exp);
      end
    end
  endtask

  task automatic test_ibuf_full();
    do_reset();
    ds_allowin = 1'b0;
    repeat (10) tick();
    n_cmp++;
    if (hs_addr.size() != 4 || dl_bus.size() != 0) begin
      n_bad++;
      $display("FAIL full_stall: got %0d reqs %0d pops, want 4 reqs 0 pops",
               hs_addr.size(), dl_bus.size());
    end
    n_cmp++;
    if (fs_to_ds_valid !== 1'b1 || fs_to_ds_bus[31:0] !== 32'hbfc00000) begin
      n_bad++;
      $display("FAIL full_head: got valid %b pc %h, want 1 bfc00000",
               fs_to_ds_valid, fs_to_ds_bus[31:0]);
    end
    ds_allowin = 1'b1;
    repeat (14) tick();
    n_cmp++;
    if (hs_a(4) !== 32'hbfc00010 || hs_c(4) !== 11 || dl_c(0) !== 10) begin
      n_bad++;
      $display("FAIL full_resume: got req %h@%0d first pop @%0d, want bfc00010@11 pop @10",
               hs_a(4), hs_c(4), dl_c(0));
    end
    for (int i = 0; i < 6; i++) begin
      logic [31:0] exp;
      exp = 32'hbfc00000 + 32'(i * 4);
      n_cmp++;
      if (dl_b(i) !== {7'd0, ~exp, exp}) begin
        n_bad++;
        $display("FAIL full_deliver[%0d]: got %h, want pc %h", i, dl_b(i), exp);
      end
    end
  endtask

  task automatic test_branch();
    logic [31:0] exp_hs [0:8];
    logic [31:0] exp_dl [0:7];
    // Delay slot still in flight: bfc00014 kept, bfc00018 dropped
    do_reset();
    repeat (5) tick();
    lat = 5;
    repeat (2) tick();
    lat    = 1;
    br_bus = {1'b0, 1'b0, 1'b1, 32'hbfc00100};
    tick();
    br_bus = '0;
    repeat (12) tick();
    exp_hs = '{32'hbfc00000, 32'hbfc00004, 32'hbfc00008, 32'hbfc0000c, 32'hbfc00010,
               32'hbfc00014, 32'hbfc00018, 32'hbfc00100, 32'hbfc00104};
    exp_dl = '{32'hbfc00000, 32'hbfc00004, 32'hbfc00008, 32'hbfc0000c, 32'hbfc00010,
               32'hbfc00014, 32'hbfc00100, 32'hbfc00104};
    for (int i = 0; i < 9; i++) begin
      n_cmp++;
      if (hs_a(i) !== exp_hs[i]) begin
        n_bad++;
        $display("FAIL br_req[%0d]: got %h, want %h", i, hs_a(i), exp_hs[i]);
      end
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (dl_b(i) !== {7'd0, ~exp_dl[i], exp_dl[i]}) begin
        n_bad++;
        $display("FAIL br_deliver[%0d]: got %h, want pc %h", i, dl_b(i), exp_dl[i]);
      end
    end
    n_cmp++;
    if (hs_c(7) !== 11) begin
      n_bad++;
      $display("FAIL br_target_cycle: got %0d, want 11", hs_c(7));
    end
    // Delay slot at the buffer head: younger buffered words flushed
    do_reset();
    ds_allowin = 1'b0;
    repeat (5) tick();
    br_bus = {1'b0, 1'b0, 1'b1, 32'hbfc00100};
    tick();
    br_bus     = '0;
    ds_allowin = 1'b1;
    repeat (6) tick();
    n_cmp++;
    if (hs_a(4) !== 32'hbfc00100 || hs_c(4) !== 6) begin
      n_bad++;
      $display("FAIL brh_req: got %h@%0d, want bfc00100@6", hs_a(4), hs_c(4));
    end
    n_cmp++;
    if (dl_b(0) !== {7'd0, ~32'hbfc00000, 32'hbfc00000} ||
        dl_b(1) !== {7'd0, ~32'hbfc00100, 32'hbfc00100}) begin
      n_bad++;
      $display("FAIL brh_deliver: got %h then %h, want pc bfc00000 then bfc00100",
               dl_b(0), dl_b(1));
    end
  endtask

  task automatic test_flush();
    logic [31:0] epc;
    // Exception with two requests pending
    do_reset();
    lat = 4;
    repeat (2) tick();
    ws_ex = 1'b1;
    lat   = 1;
    tick();
    ws_ex = 1'b0;
    repeat (10) tick();
    n_cmp++;
    if (hs_a(2) !== 32'hbfc00380 || hs_c(2) !== 5) begin
      n_bad++;
      $display("FAIL ex_req: got %h@%0d, want bfc00380@5", hs_a(2), hs_c(2));
    end
    n_cmp++;
    if (dl_b(0) !== {7'd0, ~32'hbfc00380, 32'hbfc00380}) begin
      n_bad++;
      $display("FAIL ex_deliver: got %h, want pc bfc00380", dl_b(0));
    end
    // ex+eret together, then eret alone
    for (int k = 0; k < 2; k++) begin
      do_reset();
      cp0_epc = 32'hbfc00200;
      tick();
      ws_ex   = (k == 0);
      ws_eret = 1'b1;
      tick();
      ws_ex   = 1'b0;
      ws_eret = 1'b0;
      repeat (6) tick();
      epc = (k == 0) ? 32'hbfc00380 : 32'hbfc00200;
      n_cmp++;
      if (hs_a(1) !== epc || hs_c(1) !== 2) begin
        n_bad++;
        $display("FAIL flush%0d_req: got %h@%0d, want %h@2", k, hs_a(1), hs_c(1), epc);
      end
      n_cmp++;
      if (dl_b(0) !== {7'd0, ~epc, epc}) begin
        n_bad++;
        $display("FAIL flush%0d_deliver: got %h, want pc %h", k, dl_b(0), epc);
      end
    end
  endtask

  task automatic test_misaligned();
    do_reset();
    repeat (5) tick();
    lat = 5;
    repeat (2) tick();
    lat    = 1;
    br_bus = {1'b0, 1'b0, 1'b1, 32'hbfc00102};
    tick();
    br_bus = '0;
    repeat (12) tick();
    n_cmp++;
    if (hs_addr.size() != 7 || dl_bus.size() != 7) begin
      n_bad++;
      $display("FAIL adel_counts: got %0d reqs %0d pops, want 7 and 7",
               hs_addr.size(), dl_bus.size());
    end
    n_cmp++;
    if (dl_b(5) !== {7'd0, ~32'hbfc00014, 32'hbfc00014}) begin
      n_bad++;
      $display("FAIL adel_slot: got %h, want pc bfc00014", dl_b(5));
    end
    n_cmp++;
    if (dl_b(6) !== {1'b0, 1'b1, 5'h04, 32'd0, 32'hbfc00102}) begin
      n_bad++;
      $display("FAIL adel_entry: got %h, want %h", dl_b(6),
               {1'b0, 1'b1, 5'h04, 32'd0, 32'hbfc00102});
    end
    ws_ex = 1'b1;
    tick();
    ws_ex = 1'b0;
    repeat (4) tick();
    n_cmp++;
    if (hs_a(7) !== 32'hbfc00380) begin
      n_bad++;
      $display("FAIL adel_resume: got %h, want bfc00380", hs_a(7));
    end
  endtask

  task automatic test_bd();
    do_reset();
    ds_allowin = 1'b0;
    repeat (4) tick();
    br_bus = {1'b1, 34'd0};
    tick();
    br_bus     = '0;
    ds_allowin = 1'b1;
    repeat (4) tick();
    n_cmp++;
    if (dl_b(0) !== {1'b1, 6'd0, ~32'hbfc00000, 32'hbfc00000}) begin
      n_bad++;
      $display("FAIL bd_set: got %h, want bd=1 pc bfc00000", dl_b(0));
    end
    n_cmp++;
    if (dl_b(1) !== {1'b0, 6'd0, ~32'hbfc00004, 32'hbfc00004}) begin
      n_bad++;
      $display("FAIL bd_clear: got %h, want bd=0 pc bfc00004", dl_b(1));
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_slow_response();
    test_ibuf_full();
    test_branch();
    test_flush();
    test_misaligned();
    test_bd();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
